// File: rtl/wb_queue.sv
// -----------------------------------------------------------------------------
// wb_queue -- write-back queue in front of the register file's single write port
//
// Collects completed results from the ALU (port A) and the load unit (port B),
// keeps them in acceptance order in a small circular FIFO, and drains one entry
// per cycle into the register file. Decode can ask whether a source register
// still has a queued write and can pick up the youngest queued value for it.
//
// Parameters
//   DEPTH  queue entries (power of 2, >= 2)
//   AW     register address width
//   DW     data width
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   a_valid/a_ready     ALU result handshake, a_addr/a_data payload
//   b_valid/b_ready     load result handshake, b_addr/b_data payload
//   w_enable/w_addr/w_data  register-file write port (always accepted)
//   rs1, rs2            decode source registers
//   pend1, pend2        source register has a queued write
//   fwd1, fwd2          youngest queued data for that register (0 if none)
//   count               occupied entries
// -----------------------------------------------------------------------------
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [AW-1:0]            a_addr,
  input  logic [DW-1:0]            a_data,

  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [AW-1:0]            b_addr,
  input  logic [DW-1:0]            b_data,

  output logic                     w_enable,
  output logic [AW-1:0]            w_addr,
  output logic [DW-1:0]            w_data,

  input  logic [AW-1:0]            rs1,
  input  logic [AW-1:0]            rs2,
  output logic                     pend1,
  output logic                     pend2,
  output logic [DW-1:0]            fwd1,
  output logic [DW-1:0]            fwd2,

  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  // Storage: payload arrays carry no reset; occupancy is tracked by the
  // per-entry valid bits and the counter, which are reset.
  logic [AW-1:0]    mem_addr [DEPTH];
  logic [DW-1:0]    mem_data [DEPTH];
  logic [DEPTH-1:0] ent_vld;

  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;

  logic             not_full;
  logic             acc_a;
  logic             acc_b;
  logic [AW-1:0]    in_addr;
  logic [DW-1:0]    in_data;
  logic             store;
  logic             pop;
  logic [PW-1:0]    slot;

  // Readiness looks only at the registered count, so a same-cycle drain
  // never feeds back into acceptance.
  assign not_full = (count < FULL_CNT);
  assign a_ready  = ~rst & not_full;
  assign b_ready  = ~rst & not_full & ~a_valid;

  assign acc_a    = a_valid & a_ready;
  assign acc_b    = b_valid & b_ready;
  assign in_addr  = acc_a ? a_addr : b_addr;
  assign in_data  = acc_a ? a_data : b_data;

  // Writes to x0 complete their handshake but are dropped here.
  assign store    = (acc_a | acc_b) & (in_addr != '0);

  // The register file never stalls, so the head leaves on every cycle the
  // queue is non-empty. No input-to-output bypass: an entry must be stored
  // before it can appear on the write port.
  assign w_enable = ~rst & (count != '0);
  assign w_addr   = mem_addr[head];
  assign w_data   = mem_data[head];
  assign pop      = w_enable;

  // Control state: pointers, occupancy and entry valids.
  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (store) begin
        tail          <= tail + 1'b1;
        ent_vld[tail] <= 1'b1;
      end
      if (pop) begin
        head          <= head + 1'b1;
        ent_vld[head] <= 1'b0;
      end
      case ({store, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload write: head==tail with both store and pop cannot occur, since
  // that needs the queue to be simultaneously empty (no pop) and full (no store).
  always_ff @(posedge clk) begin
    if (store) begin
      mem_addr[tail] <= in_addr;
      mem_data[tail] <= in_data;
    end
  end

  // Hazard lookup: walk from oldest (head) to youngest so later matches
  // overwrite earlier ones and the youngest value wins. The head entry is
  // included even though it is being written this cycle.
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    fwd1  = '0;
    fwd2  = '0;
    slot  = head;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PW'(i);
      if (ent_vld[slot] && (mem_addr[slot] == rs1) && (rs1 != '0)) begin
        pend1 = 1'b1;
        fwd1  = mem_data[slot];
      end
      if (ent_vld[slot] && (mem_addr[slot] == rs2) && (rs2 != '0)) begin
        pend2 = 1'b1;
        fwd2  = mem_data[slot];
      end
    end
    if (rst) begin
      pend1 = 1'b0;
      pend2 = 1'b0;
      fwd1  = '0;
      fwd2  = '0;
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// -----------------------------------------------------------------------------
// tb_wb_queue -- self-checking bench for wb_queue
//
// Accepted writes (non-x0) are pushed to a scoreboard queue when the handshake
// is seen; a monitor pops and compares every register-file write. Each scenario
// task also checks handshakes, occupancy and hazard outputs inline.
// -----------------------------------------------------------------------------
module tb_wb_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_valid = 1'b0;
  logic          a_ready;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_data = '0;
  logic          b_valid = 1'b0;
  logic          b_ready;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_data = '0;
  logic          w_enable;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic [AW-1:0] rs1 = '0;
  logic [AW-1:0] rs2 = '0;
  logic          pend1;
  logic          pend2;
  logic [DW-1:0] fwd1;
  logic [DW-1:0] fwd2;
  logic [CW-1:0] count;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t sb[$];
  wr_t mon_exp;
  int  total = 0;
  int  bad   = 0;

  wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .w_enable(w_enable), .w_addr(w_addr), .w_data(w_data),
    .rs1(rs1), .rs2(rs2), .pend1(pend1), .pend2(pend2),
    .fwd1(fwd1), .fwd2(fwd2), .count(count)
  );

  always #5 clk = ~clk;

  // Write-port monitor against the scoreboard.
  always @(negedge clk) begin
    if (w_enable === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", w_addr, w_data);
      end else begin
        mon_exp = sb.pop_front();
        if (w_addr !== mon_exp.addr || w_data !== mon_exp.data) begin
          bad++;
          $display("FAIL write_order: got addr=%0d data=%h, required addr=%0d data=%h",
                   w_addr, w_data, mon_exp.addr, mon_exp.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    if (addr != '0) sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1; a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL reset_a_ready: got %b, required 0", a_ready); end
      total++; if (w_enable !== 1'b0) begin bad++; $display("FAIL reset_w_enable: got %b, required 0", w_enable); end
      total++; if (count !== '0) begin bad++; $display("FAIL reset_count: got %0d, required 0", count); end
    end
    step(); rst = 1'b0; a_valid = 1'b0;
    @(negedge clk);
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL release_a_ready: got %b, required 1", a_ready); end
    total++; if (count !== '0) begin bad++; $display("FAIL release_count: got %0d, required 0", count); end
  endtask

  task automatic test_single();
    step(); a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF; rs1 = 5'd5;
    @(negedge clk);
    total++; if (pend1 !== 1'b0) begin bad++; $display("FAIL single_pend_before: got %b, required 0", pend1); end
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %b, required 1", a_ready); end
    if (a_ready === 1'b1) sb_push(a_addr, a_data);
    step(); a_valid = 1'b0;
    @(negedge clk);
    total++; if (w_enable !== 1'b1) begin bad++; $display("FAIL single_w_enable: got %b, required 1", w_enable); end
    total++; if (pend1 !== 1'b1) begin bad++; $display("FAIL single_pend1: got %b, required 1", pend1); end
    total++; if (fwd1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_fwd1: got %h, required deadbeef", fwd1); end
    total++; if (count !== CW'(1)) begin bad++; $display("FAIL single_count: got %0d, required 1", count); end
    step();
    @(negedge clk);
    total++; if (w_enable !== 1'b0) begin bad++; $display("FAIL single_after_w_enable: got %b, required 0", w_enable); end
    total++; if (pend1 !== 1'b0) begin bad++; $display("FAIL single_after_pend1: got %b, required 0", pend1); end
    total++; if (fwd1 !== '0) begin bad++; $display("FAIL single_after_fwd1: got %h, required 0", fwd1); end
  endtask

  task automatic test_priority();
    step();
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h0000_0111;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h0000_0222;
    @(negedge clk);
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL prio_a_ready: got %b, required 1", a_ready); end
    total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL prio_b_ready: got %b, required 0", b_ready); end
    if (a_ready === 1'b1) sb_push(a_addr, a_data);
    if (b_ready === 1'b1) sb_push(b_addr, b_data);
    step(); a_valid = 1'b0;
    @(negedge clk);
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL prio_b_held_ready: got %b, required 1", b_ready); end
    total++; if (w_addr !== 5'd1) begin bad++; $display("FAIL prio_first_addr: got %0d, required 1", w_addr); end
    if (b_ready === 1'b1) sb_push(b_addr, b_data);
    step(); b_valid = 1'b0;
    @(negedge clk);
    total++; if (w_enable !== 1'b1 || w_addr !== 5'd2) begin
      bad++; $display("FAIL prio_second_write: got en=%b addr=%0d, required en=1 addr=2", w_enable, w_addr);
    end
    step();
  endtask

  task automatic test_full();
    int n;
    for (int i = 0; i < 8; i++) begin
      step();
      a_valid = 1'b1; a_addr = AW'(8 + i); a_data = $urandom;
      b_valid = 1'b1; b_addr = 5'd20; b_data = 32'hBBBB_0000;
      @(negedge clk);
      total++; if (count !== CW'((i == 0) ? 0 : 1)) begin
        bad++; $display("FAIL full_count_%0d: got %0d, required %0d", i, count, (i == 0) ? 0 : 1);
      end
      total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL full_a_ready_%0d: got %b, required 1", i, a_ready); end
      total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL full_b_ready_%0d: got %b, required 0", i, b_ready); end
      if (a_ready === 1'b1) sb_push(a_addr, a_data);
      else if (b_ready === 1'b1) sb_push(b_addr, b_data);
    end
    step(); a_valid = 1'b0; b_valid = 1'b0;
    n = 0;
    while (count !== '0 && n < 16) begin @(negedge clk); n++; end
    total++; if (count !== '0) begin bad++; $display("FAIL full_drain: got count=%0d, required 0", count); end
  endtask

  task automatic test_x0_fwd();
    rs1 = 5'd0; rs2 = 5'd7;
    step(); a_valid = 1'b1; a_addr = 5'd0; a_data = 32'd1;
    @(negedge clk);
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL x0_ready: got %b, required 1", a_ready); end
    step(); a_addr = 5'd7; a_data = 32'd10;
    @(negedge clk);
    total++; if (count !== '0) begin bad++; $display("FAIL x0_not_stored: got count=%0d, required 0", count); end
    total++; if (pend1 !== 1'b0) begin bad++; $display("FAIL x0_pend1: got %b, required 0", pend1); end
    if (a_ready === 1'b1) sb_push(a_addr, a_data);
    step(); a_addr = 5'd7; a_data = 32'd20;
    @(negedge clk);
    total++; if (pend2 !== 1'b1) begin bad++; $display("FAIL fwd_pend2_first: got %b, required 1", pend2); end
    total++; if (fwd2 !== 32'd10) begin bad++; $display("FAIL fwd_fwd2_first: got %0d, required 10", fwd2); end
    if (a_ready === 1'b1) sb_push(a_addr, a_data);
    step(); a_valid = 1'b0;
    @(negedge clk);
    total++; if (pend2 !== 1'b1) begin bad++; $display("FAIL fwd_pend2_second: got %b, required 1", pend2); end
    total++; if (fwd2 !== 32'd20) begin bad++; $display("FAIL fwd_fwd2_second: got %0d, required 20", fwd2); end
    step();
    @(negedge clk);
    total++; if (pend2 !== 1'b0 || fwd2 !== '0) begin
      bad++; $display("FAIL fwd_cleared: got pend2=%b fwd2=%0d, required 0/0", pend2, fwd2);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    for (int i = 0; i < 24; i++) begin
      step();
      a_valid = 1'($urandom_range(0, 1));
      b_valid = 1'($urandom_range(0, 1));
      a_addr  = AW'($urandom_range(0, 31));
      b_addr  = AW'($urandom_range(0, 31));
      a_data  = $urandom;
      b_data  = $urandom;
      @(negedge clk);
      total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL b2b_a_ready_%0d: got %b, required 1", i, a_ready); end
      total++; if (b_ready !== ~a_valid) begin bad++; $display("FAIL b2b_b_ready_%0d: got %b, required %b", i, b_ready, ~a_valid); end
      if (a_valid && a_ready === 1'b1) sb_push(a_addr, a_data);
      else if (b_valid && b_ready === 1'b1) sb_push(b_addr, b_data);
    end
    step(); a_valid = 1'b0; b_valid = 1'b0;
    n = 0;
    while (count !== '0 && n < 16) begin @(negedge clk); n++; end
    total++; if (count !== '0) begin bad++; $display("FAIL b2b_drain: got count=%0d, required 0", count); end
  endtask

  task automatic test_reset_mid();
    rs1 = 5'd6;
    step(); a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hAAAA_0003;
    @(negedge clk); if (a_ready === 1'b1) sb_push(a_addr, a_data);
    step(); a_addr = 5'd4; a_data = 32'hAAAA_0004;
    @(negedge clk); if (a_ready === 1'b1) sb_push(a_addr, a_data);
    step(); a_addr = 5'd6; a_data = 32'hAAAA_0006;
    @(negedge clk);
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL mid_last_ready: got %b, required 1", a_ready); end
    // Entry for r6 lands in the queue but is discarded by the reset below.
    step(); rst = 1'b1; a_addr = 5'd9; a_data = 32'hAAAA_0009;
    @(negedge clk);
    total++; if (w_enable !== 1'b0) begin bad++; $display("FAIL mid_rst_w_enable: got %b, required 0", w_enable); end
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_a_ready: got %b, required 0", a_ready); end
    total++; if (pend1 !== 1'b0) begin bad++; $display("FAIL mid_rst_pend1: got %b, required 0", pend1); end
    step(); rst = 1'b0; a_valid = 1'b0;
    @(negedge clk);
    total++; if (count !== '0) begin bad++; $display("FAIL mid_count: got %0d, required 0", count); end
    total++; if (w_enable !== 1'b0) begin bad++; $display("FAIL mid_after_w_enable: got %b, required 0", w_enable); end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_full();
    test_x0_fwd();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    total++; if (sb.size() != 0) begin
      bad++; $display("FAIL scoreboard_empty: got %0d pending writes, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
